// File: rtl/port_tx_feeder_if.sv
// Bundle between the tx feeder, its two fwft FIFOs (frame length and byte data)
// and the MAC AXI-Stream transmit port.
interface port_tx_feeder_if;
    logic        len_empty;
    logic [15:0] len_dout;
    logic        len_ren;
    logic        data_empty;
    logic [7:0]  data_dout;
    logic        data_ren;
    logic [7:0]  tx_axis_tdata;
    logic        tx_axis_tvalid;
    logic        tx_axis_tlast;
    logic        tx_axis_tready;

    modport master (
        input  len_empty, len_dout, data_empty, data_dout, tx_axis_tready,
        output len_ren, data_ren, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast
    );

    modport slave (
        output len_empty, len_dout, data_empty, data_dout, tx_axis_tready,
        input  len_ren, data_ren, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast
    );
endinterface

// File: rtl/port_tx_feeder.sv
// Pops one length word per frame, streams that many bytes to the MAC, zero-pads
// runts to the minimum size, drains illegal frames and inserts an idle gap.
module port_tx_feeder #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int IFG_CYCLES      = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    port_tx_feeder_if.master  bus,
    output logic [31:0]       frames_sent,
    output logic              frame_dropped,
    output logic              underrun
);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAD, S_DROP, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] pad_q, pad_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] frames_sent_q, frames_sent_d;
    logic        underrun_seen_q, underrun_seen_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            remaining_q     <= '0;
            pad_q           <= '0;
            gap_q           <= '0;
            frames_sent_q   <= '0;
            underrun_seen_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            pad_q           <= pad_d;
            gap_q           <= gap_d;
            frames_sent_q   <= frames_sent_d;
            underrun_seen_q <= underrun_seen_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        remaining_d        = remaining_q;
        pad_d              = pad_q;
        gap_d              = gap_q;
        frames_sent_d      = frames_sent_q;
        underrun_seen_d    = underrun_seen_q;
        bus.len_ren        = 1'b0;
        bus.data_ren       = 1'b0;
        bus.tx_axis_tdata  = 8'h00;
        bus.tx_axis_tvalid = 1'b0;
        bus.tx_axis_tlast  = 1'b0;
        frame_dropped      = 1'b0;
        underrun           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.len_empty) begin
                    bus.len_ren     = 1'b1;
                    remaining_d     = bus.len_dout;
                    underrun_seen_d = 1'b0;
                    if (bus.len_dout == 16'd0 || bus.len_dout > MAX_LEN) begin
                        // A zero-length word has no bytes behind it, so skip the drain
                        frame_dropped = 1'b1;
                        pad_d         = 16'd0;
                        state_d       = (bus.len_dout == 16'd0) ? S_IDLE : S_DROP;
                    end else begin
                        pad_d   = (bus.len_dout < MIN_LEN) ? (MIN_LEN - bus.len_dout) : 16'd0;
                        state_d = S_SEND;
                    end
                end
            end

            S_SEND: begin
                bus.tx_axis_tdata  = bus.data_dout;
                bus.tx_axis_tvalid = !bus.data_empty;
                bus.tx_axis_tlast  = (remaining_q == 16'd1) && (pad_q == 16'd0);
                bus.data_ren       = !bus.data_empty && bus.tx_axis_tready;
                if (bus.data_empty && !underrun_seen_q) begin
                    underrun        = 1'b1;
                    underrun_seen_d = 1'b1;
                end
                if (!bus.data_empty && bus.tx_axis_tready) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        if (pad_q != 16'd0) begin
                            state_d = S_PAD;
                        end else begin
                            state_d       = S_GAP;
                            gap_d         = GAP_LOAD;
                            frames_sent_d = frames_sent_q + 32'd1;
                        end
                    end
                end
            end

            S_PAD: begin
                bus.tx_axis_tvalid = 1'b1;
                bus.tx_axis_tlast  = (pad_q == 16'd1);
                if (bus.tx_axis_tready) begin
                    pad_d = pad_q - 16'd1;
                    if (pad_q == 16'd1) begin
                        state_d       = S_GAP;
                        gap_d         = GAP_LOAD;
                        frames_sent_d = frames_sent_q + 32'd1;
                    end
                end
            end

            S_DROP: begin
                bus.data_ren = !bus.data_empty && (remaining_q != 16'd0);
                if (remaining_q == 16'd0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else if (!bus.data_empty) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign frames_sent = frames_sent_q;

endmodule
